// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and instruction decode for the multi-cycle ARM controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_BRANCH,
    S_FAULT
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [5:0] F_AND   = 6'b000000;
  localparam logic [5:0] F_SUB   = 6'b000100;
  localparam logic [5:0] F_ADD   = 6'b001000;
  localparam logic [5:0] F_ORR   = 6'b011000;
  localparam logic [5:0] F_CMP   = 6'b010101;
  localparam logic [5:0] F_SHIFT = 6'b011010;
  localparam logic [5:0] F_STR   = 6'b011000;
  localparam logic [5:0] F_LDR   = 6'b011001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_LSR = 3'b100;
  localparam logic [2:0] ALU_LSL = 3'b101;

  localparam logic [1:0] IMM_SHAMT5 = 2'd0;
  localparam logic [1:0] IMM_12     = 2'd1;
  localparam logic [1:0] IMM_24     = 2'd2;

  localparam logic [1:0] BSEL_REG  = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [2:0] {
    C_NONE,
    C_ALU,
    C_CMP,
    C_SHIFT,
    C_LDR,
    C_STR,
    C_BR
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] alu;
  } decode_t;

  // C_NONE marks an undecodable instruction.
  function automatic decode_t decode(input logic [1:0] op, input logic [5:0] funct,
                                     input logic [1:0] sh);
    decode_t d;
    d.cls = C_NONE;
    d.alu = ALU_ADD;
    case (op)
      OP_DP: begin
        case (funct)
          F_ADD: begin d.cls = C_ALU; d.alu = ALU_ADD; end
          F_SUB: begin d.cls = C_ALU; d.alu = ALU_SUB; end
          F_AND: begin d.cls = C_ALU; d.alu = ALU_AND; end
          F_ORR: begin d.cls = C_ALU; d.alu = ALU_ORR; end
          F_CMP: begin d.cls = C_CMP; d.alu = ALU_SUB; end
          F_SHIFT: begin
            if (sh == SH_LSL) begin
              d.cls = C_SHIFT;
              d.alu = ALU_LSL;
            end else if (sh == SH_LSR) begin
              d.cls = C_SHIFT;
              d.alu = ALU_LSR;
            end
          end
          default: d.cls = C_NONE;
        endcase
      end
      OP_MEM: begin
        if (funct == F_STR) d.cls = C_STR;
        else if (funct == F_LDR) d.cls = C_LDR;
      end
      OP_BR: d.cls = C_BR;
      default: d.cls = C_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluator against NZCV
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // NV returns 0 here; the controller flags it as illegal separately.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_arm_controller.sv
// rtl/multicycle_arm_controller.sv - multi-cycle ARM-subset control FSM with memory handshake and timeout fault
module multicycle_arm_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter bit COND_EXEC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic [3:0]            nzcv,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  reg_sel,
  output logic                  alu_a_sel,
  output logic [1:0]            alu_b_sel,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            imm_src,
  output logic                  flag_write,
  output logic                  result_sel,
  output logic                  instr_done,
  output logic                  illegal,
  output logic                  fault
);

  localparam int CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_e           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic [2:0]       alu_code;
  logic [3:0]       cond_eff;
  logic             cond_pass;
  decode_t          dec;

  logic unused_bits;
  assign unused_bits = ^{instr[19:7], instr[4:0]};

  assign cond_eff = COND_EXEC ? instr[31:28] : COND_AL;
  assign dec      = decode(instr[27:26], instr[25:20], instr[6:5]);
  assign fault    = (state == S_FAULT);

  cond_check u_cond_check (
    .cond (cond_eff),
    .nzcv (nzcv),
    .pass (cond_pass)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      // Counts only stalls within one state; any exit or handshake restarts it.
      if (waiting && state_next == state) wait_cnt <= wait_cnt + CNT_W'(1);
      else wait_cnt <= '0;
    end
  end

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    reg_sel     = 1'b0;
    alu_a_sel   = 1'b0;
    alu_b_sel   = BSEL_REG;
    alu_code    = ALU_ADD;
    imm_src     = IMM_SHAMT5;
    flag_write  = 1'b0;
    result_sel  = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = S_FETCH;
        if (cond_eff == COND_NV) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end else if (!cond_pass) begin
          instr_done = 1'b1;
        end else begin
          case (dec.cls)
            C_ALU, C_CMP, C_SHIFT: state_next = S_EXEC_R;
            C_LDR, C_STR:          state_next = S_MEM_ADDR;
            C_BR:                  state_next = S_BRANCH;
            default: begin
              illegal    = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_R: begin
        alu_code   = dec.alu;
        instr_done = 1'b1;
        state_next = S_FETCH;
        if (dec.cls == C_CMP) begin
          flag_write = 1'b1;
        end else begin
          reg_write  = 1'b1;
          result_sel = 1'b1;
        end
        if (dec.cls == C_SHIFT) begin
          alu_a_sel = 1'b1;
          alu_b_sel = BSEL_IMM;
          imm_src   = IMM_SHAMT5;
        end
      end
      S_MEM_ADDR: begin
        alu_b_sel  = BSEL_IMM;
        imm_src    = IMM_12;
        state_next = (dec.cls == C_LDR) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        reg_sel    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        alu_b_sel  = BSEL_IMM;
        imm_src    = IMM_24;
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase

    waiting = mem_req & ~mem_ready;
    if (MEM_TIMEOUT > 0 && waiting && wait_cnt == CNT_W'(TO_LAST)) state_next = S_FAULT;

    alu_control = ALU_CTRL_W'(alu_code);

    if (!rst) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      reg_write   = 1'b0;
      reg_sel     = 1'b0;
      alu_a_sel   = 1'b0;
      alu_b_sel   = '0;
      alu_control = '0;
      imm_src     = '0;
      flag_write  = 1'b0;
      result_sel  = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule
